// File: rtl/mod_instruction_fetch.sv
// Instruction-fetch stage: PC, ROM word address, IF/ID register.
// Ports: clk/reset, stall/redirect(_pc) in, imem_* ROM link, if_* IF/ID out, halted.
module mod_instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [29:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        imem_end,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] PC0  = RESET_PC & ~32'h3;
  localparam logic [3:0]  LAST = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [3:0]  drain_cnt, cnt_n;
  logic [31:0] instr_n, ifpc_n, p4_n;
  logic        valid_n, halted_n;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign imem_address = pc[31:2];
  assign pc_plus4     = pc + 32'd4;
  assign target       = redirect_pc & ~32'h3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= PC0;
      drain_cnt      <= 4'd0;
      if_instruction <= 32'd0;
      if_pc          <= 32'd0;
      if_pc_plus4    <= 32'd0;
      if_valid       <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      drain_cnt      <= cnt_n;
      if_instruction <= instr_n;
      if_pc          <= ifpc_n;
      if_pc_plus4    <= p4_n;
      if_valid       <= valid_n;
      halted         <= halted_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    cnt_n    = drain_cnt;
    instr_n  = if_instruction;
    ifpc_n   = if_pc;
    p4_n     = if_pc_plus4;
    valid_n  = if_valid;
    halted_n = halted;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          instr_n = 32'd0;
        end else if (stall) begin
          // everything holds
        end else if (imem_end) begin
          valid_n = 1'b0;
          instr_n = 32'd0;
          cnt_n   = 4'd0;
          state_n = DRAIN;
        end else begin
          instr_n = imem_instruction;
          ifpc_n  = pc;
          p4_n    = pc_plus4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
        end
      end
      DRAIN: begin
        valid_n = 1'b0;
        instr_n = 32'd0;
        if (redirect) begin
          // branch resolved from the last instructions in flight
          pc_n    = target;
          cnt_n   = 4'd0;
          state_n = FETCH;
        end else if (!stall) begin
          if (drain_cnt == LAST) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end else begin
            cnt_n = drain_cnt + 4'd1;
          end
        end
      end
      HALT: begin
        valid_n  = 1'b0;
        instr_n  = 32'd0;
        halted_n = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Self-checking bench for mod_instruction_fetch.
// Table-driven vectors plus directed multi-cycle sequences.
module tb_mod_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [29:0] imem_address;
  logic [31:0] imem_instruction;
  logic        imem_end;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;
  logic        if_valid, halted;
  logic        rom_mode;

  logic        reset_w;
  logic [29:0] addr_w;
  logic [31:0] instr_w, pc_w, p4_w;
  logic        valid_w, halted_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_instruction_fetch dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_address(imem_address),
    .imem_instruction(imem_instruction),
    .imem_end(imem_end),
    .if_instruction(if_instruction), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_valid(if_valid),
    .halted(halted)
  );

  mod_instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset_w), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'd0),
    .imem_address(addr_w),
    .imem_instruction(32'h1234_5678),
    .imem_end(1'b0),
    .if_instruction(instr_w), .if_pc(pc_w),
    .if_pc_plus4(p4_w), .if_valid(valid_w),
    .halted(halted_w)
  );

  // mode 0: one-word program; mode 1: address-tagged data, never ends
  always_comb begin
    if (rom_mode) begin
      imem_instruction = {16'hC0DE, imem_address[15:0]};
      imem_end         = 1'b0;
    end else begin
      imem_instruction = (imem_address == 30'd0) ? 32'h2001_000D : 32'd0;
      imem_end         = (imem_address != 30'd0);
    end
  end

  function automatic logic [31:0] romd(input int a);
    return {16'hC0DE, 16'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ei, epc, ep4;
    logic [29:0] ea;
    logic        eh;
  } vec_t;

  vec_t v[10];
  logic hold_ok;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; rom_mode = 1'b0; reset_w = 1'b1;

    // rst stl rdr rpc | valid instr pc plus4 addr halted
    v[0] = '{1,0,0,32'h0, 0,32'h0,32'h0,32'h0,30'd0,0};
    v[1] = '{1,0,0,32'h0, 0,32'h0,32'h0,32'h0,30'd0,0};
    v[2] = '{0,0,0,32'h0, 1,32'h2001_000D,32'h0,32'h4,30'd1,0};
    v[3] = '{0,0,0,32'h0, 0,32'h0,32'h0,32'h4,30'd1,0};
    v[4] = '{0,0,0,32'h0, 0,32'h0,32'h0,32'h4,30'd1,0};
    v[5] = '{0,0,0,32'h0, 0,32'h0,32'h0,32'h4,30'd1,0};
    v[6] = '{0,0,0,32'h0, 0,32'h0,32'h0,32'h4,30'd1,0};
    v[7] = '{0,0,0,32'h0, 0,32'h0,32'h0,32'h4,30'd1,1};
    v[8] = '{0,0,1,32'h40,0,32'h0,32'h0,32'h4,30'd1,1};
    v[9] = '{0,1,0,32'h0, 0,32'h0,32'h0,32'h4,30'd1,1};

    for (int i = 0; i < 10; i++) begin
      reset = v[i].rst; stall = v[i].stl;
      redirect = v[i].rdr; redirect_pc = v[i].rpc;
      if (i == 1) reset_w = 1'b0;
      step();
      chk($sformatf("v%0d valid", i), 32'(if_valid), 32'(v[i].ev));
      chk($sformatf("v%0d instr", i), if_instruction, v[i].ei);
      chk($sformatf("v%0d pc", i), if_pc, v[i].epc);
      chk($sformatf("v%0d pc4", i), if_pc_plus4, v[i].ep4);
      chk($sformatf("v%0d addr", i), 32'(imem_address), 32'(v[i].ea));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(v[i].eh));
      if (i == 0) chk("wrap reset addr", 32'(addr_w), 32'h3FFF_FFFF);
      if (i == 1) begin
        chk("wrap pc", pc_w, 32'hFFFF_FFFC);
        chk("wrap pc4", p4_w, 32'h0);
        chk("wrap addr", 32'(addr_w), 32'h0);
        chk("wrap valid", 32'(valid_w), 32'h1);
      end
    end

    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!halted || if_valid || imem_address != 30'd1) hold_ok = 1'b0;
    end
    chk("halt sticky", 32'(hold_ok), 32'h1);

    // reset from HALT
    redirect = 1'b0; reset = 1'b1;
    step();
    chk("rst halt h", 32'(halted), 32'h0);
    chk("rst halt addr", 32'(imem_address), 32'h0);
    reset = 1'b0;

    // redirect during second DRAIN cycle
    step(); step(); step();
    chk("drain valid", 32'(if_valid), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk("rd drain addr", 32'(imem_address), 32'h0);
    chk("rd drain h", 32'(halted), 32'h0);
    step();
    chk("rd drain instr", if_instruction, 32'h2001_000D);
    chk("rd drain valid", 32'(if_valid), 32'h1);
    chk("rd drain h2", 32'(halted), 32'h0);

    // redirect beats imem_end in FETCH (pc=4 here, end asserted)
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk("rd end addr", 32'(imem_address), 32'h0);
    step();
    chk("rd end valid", 32'(if_valid), 32'h1);
    chk("rd end instr", if_instruction, 32'h2001_000D);

    // stall at pc=8 with address-tagged ROM
    rom_mode = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step();
    chk("pre stall addr", 32'(imem_address), 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d addr", i), 32'(imem_address), 32'd2);
      chk($sformatf("stall%0d pc", i), if_pc, 32'h4);
      chk($sformatf("stall%0d instr", i), if_instruction, romd(1));
      chk($sformatf("stall%0d valid", i), 32'(if_valid), 32'h1);
    end
    stall = 1'b0;
    step();
    chk("release pc", if_pc, 32'h8);
    chk("release instr", if_instruction, romd(2));
    chk("release pc4", if_pc_plus4, 32'hC);

    // redirect with stall, unaligned target
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0013;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("redir addr", 32'(imem_address), 32'd4);
    chk("redir valid", 32'(if_valid), 32'h0);
    chk("redir instr", if_instruction, 32'h0);
    step();
    chk("redir pc", if_pc, 32'h10);
    chk("redir data", if_instruction, romd(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
